mem_access_unit: RTL and testbench

Parametrised memory access unit between the control unit and a byte-wide RAM. It replaces the fixed MAR/MDR word path with a sequenced engine. It accepts one load or store request of byte, halfword or word size and performs it as big-endian byte-serial transfers over a per-byte MOV/MOC handshake. It returns an assembled, zero- or sign-extended load word, plus done/error pulses.

---
 rtl/mau_pkg.sv | 32 +++
 rtl/mau_extend.sv | 31 +++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared encodings and helpers for the memory access unit (mem_access_unit).
package mau_pkg;

    localparam int unsigned DT_W    = 2;
    localparam int unsigned BASE_W  = 32;
    localparam int unsigned BCNT_W  = 3;

    typedef enum logic [DT_W-1:0] {
        DT_BYTE    = 2'b00,
        DT_HALF    = 2'b01,
        DT_WORD    = 2'b10,
        DT_ILLEGAL = 2'b11
    } dt_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BUS  = 3'd1,
        GAP  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_e;

    // Number of bytes moved for a given size code.
    function automatic logic [BCNT_W-1:0] byte_count(input logic [DT_W-1:0] dt);
        case (dt)
            DT_BYTE: return 3'd1;
            DT_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mau_extend.sv
// Zero/sign extension of an assembled 8/16/32-bit load value to DATA_W.
module mau_extend
    import mau_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [BASE_W-1:0] i_val,
    input  logic [DT_W-1:0]   i_dt,
    input  logic              i_sext,
    output logic [DATA_W-1:0] o_val_c
);

    always_comb begin
        o_val_c = '0;
        case (i_dt)
            DT_BYTE: begin
                o_val_c      = {DATA_W{i_sext & i_val[7]}};
                o_val_c[7:0] = i_val[7:0];
            end
            DT_HALF: begin
                o_val_c       = {DATA_W{i_sext & i_val[15]}};
                o_val_c[15:0] = i_val[15:0];
            end
            default: begin
                o_val_c       = {DATA_W{i_sext & i_val[31]}};
                o_val_c[31:0] = i_val;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-serial big-endian load/store engine with per-byte MOV/MOC handshake.
// Optional MAU_ALIGN_CHECK_EN rejects misaligned halfword/word requests.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              rw,
    input  logic [DT_W-1:0]   dt,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_mov,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_moc
);

    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_e              r_state;
    logic [DT_W-1:0]     r_dt;
    logic                r_sext;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_idx;
    logic [WAIT_W-1:0]   r_wait;
    logic [BASE_W-1:0]   r_shift;

    logic [BCNT_W-1:0]   w_n;
    logic [1:0]          w_k;
    logic [1:0]          w_acc_k;
    logic                w_last;
    logic                w_misalign;
    logic [BASE_W-1:0]   w_shift_next;
    logic [DATA_W-1:0]   w_ext;

    // w_k is the big-endian byte position of the current transfer index.
    assign w_n     = byte_count(r_dt);
    assign w_k     = 2'(w_n - 3'd1 - {1'b0, r_idx});
    assign w_acc_k = 2'(byte_count(dt) - 3'd1);
    assign w_last  = ({1'b0, r_idx} == (w_n - 3'd1));

`ifdef MAU_ALIGN_CHECK_EN
    assign w_misalign = ((dt == DT_HALF) && addr[0]) ||
                        ((dt == DT_WORD) && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Shift register with the byte arriving this cycle merged in.
    always_comb begin
        w_shift_next = r_shift;
        w_shift_next[{w_k, 3'b000} +: 8] = mem_rdata;
    end

    mau_extend #(.DATA_W(DATA_W)) u_extend (
        .i_val   (w_shift_next),
        .i_dt    (r_dt),
        .i_sext  (r_sext),
        .o_val_c (w_ext)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= IDLE;
            r_dt      <= DT_BYTE;
            r_sext    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_idx     <= '0;
            r_wait    <= '0;
            r_shift   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_mov   <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_dt    <= dt;
                        r_sext  <= sext;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_idx   <= '0;
                        r_wait  <= '0;
                        r_shift <= '0;
                        mem_rw  <= rw;
                        busy    <= 1'b1;
                        if ((dt == DT_ILLEGAL) || w_misalign) begin
                            r_state <= ERR;
                            err     <= 1'b1;
                        end else begin
                            r_state   <= BUS;
                            mem_mov   <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= 8'(wdata >> {w_acc_k, 3'b000});
                        end
                    end
                end
                BUS: begin
                    if (mem_moc) begin
                        r_wait  <= '0;
                        mem_mov <= 1'b0;
                        if (mem_rw) r_shift <= w_shift_next;
                        if (w_last) begin
                            r_state <= DONE;
                            done    <= 1'b1;
                            if (mem_rw) rdata <= w_ext;
                        end else begin
                            r_state <= GAP;
                            r_idx   <= 2'(r_idx + 2'd1);
                        end
                    end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
                        r_state <= ERR;
                        err     <= 1'b1;
                        mem_mov <= 1'b0;
                        r_wait  <= '0;
                    end else begin
                        r_wait <= WAIT_W'(r_wait + 1'b1);
                    end
                end
                GAP: begin
                    r_state   <= BUS;
                    r_wait    <= '0;
                    mem_mov   <= 1'b1;
                    mem_addr  <= ADDR_W'(r_addr + ADDR_W'(r_idx));
                    mem_wdata <= 8'(r_wdata >> {w_k, 3'b000});
                end
                DONE, ERR: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a byte RAM responder.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req = 1'b0;
    logic        rw = 1'b0;
    logic [1:0]  dt = 2'b00;
    logic        sext = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err, mem_mov, mem_rw;
    logic [31:0] rdata;
    logic [7:0]  mem_addr, mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_moc = 1'b0;

    mem_access_unit #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .clr(clr), .req(req), .rw(rw), .dt(dt), .sext(sext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_moc(mem_moc)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mem [256];
    int          done_cyc, err_cyc, mov_cnt, busy_bad, n_addr;
    logic [31:0] mov_mask;
    logic [7:0]  addr_log [8];
    logic        post_done, post_busy, err_mov;
    logic [31:0] exp_rdata = 32'h0;

    // Issue one request at cycle 0 and act as the RAM until done/err/abort.
    task automatic do_req(input logic i_rw, input logic [1:0] i_dt, input logic i_sext,
                          input logic [7:0] i_addr, input logic [31:0] i_wdata,
                          input int delay, input int abort_at);
        int wcnt = 0;
        done_cyc = -1; err_cyc = -1; mov_cnt = 0; busy_bad = 0; n_addr = 0;
        mov_mask = '0; err_mov = 1'b0; post_done = 1'b0; post_busy = 1'b0;
        @(negedge clk);
        rw = i_rw; dt = i_dt; sext = i_sext; addr = i_addr; wdata = i_wdata; req = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (busy !== 1'b1) busy_bad++;
            if (mem_mov === 1'b1) begin
                mov_cnt++;
                if (c < 32) mov_mask[c] = 1'b1;
            end
            if (c == abort_at) begin
                mem_moc = 1'b0;
                return;
            end
            if (done === 1'b1) begin done_cyc = c; break; end
            if (err === 1'b1) begin err_cyc = c; err_mov = mem_mov; break; end
            if (mem_mov === 1'b1) begin
                if (wcnt == 0 && n_addr < 8) begin
                    addr_log[n_addr] = mem_addr;
                    n_addr++;
                end
                if (delay >= 0 && wcnt == delay) begin
                    mem_moc = 1'b1;
                    if (mem_rw) mem_rdata = mem[mem_addr];
                    else        mem[mem_addr] = mem_wdata;
                    wcnt = 0;
                end else begin
                    mem_moc = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_moc = 1'b0;
                wcnt = 0;
            end
        end
        mem_moc = 1'b0;
        @(negedge clk);
        post_done = done;
        post_busy = busy;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy, done, err, mem_mov, mem_rw} !== 5'b0) begin n_bad++; $display("FAIL reset_flags got %b want 00000", {busy, done, err, mem_mov, mem_rw}); end
        n_cmp++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin n_bad++; $display("FAIL reset_bus got addr=%h wdata=%h want 00/00", mem_addr, mem_wdata); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 00000000", rdata); end
        clr = 1'b0;
    endtask

    task automatic test_word_load();
        mem[8'h10] = 8'h12; mem[8'h11] = 8'h34; mem[8'h12] = 8'h56; mem[8'h13] = 8'h78;
        do_req(1'b1, 2'b10, 1'b0, 8'h10, 32'h0, 0, -1);
        exp_rdata = 32'h12345678;
        n_cmp++; if (done_cyc != 8) begin n_bad++; $display("FAIL wl_done_cycle got %0d want 8", done_cyc); end
        n_cmp++; if (rdata !== exp_rdata) begin n_bad++; $display("FAIL wl_rdata got %h want %h", rdata, exp_rdata); end
        n_cmp++; if (mov_mask !== 32'h0000_00AA) begin n_bad++; $display("FAIL wl_mov_cycles got %h want 000000aa", mov_mask); end
        n_cmp++; if (n_addr != 4 || addr_log[0] !== 8'h10 || addr_log[1] !== 8'h11 || addr_log[2] !== 8'h12 || addr_log[3] !== 8'h13) begin
            n_bad++; $display("FAIL wl_addr_seq got n=%0d %h %h %h %h want 4 10 11 12 13", n_addr, addr_log[0], addr_log[1], addr_log[2], addr_log[3]);
        end
        n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL wl_busy got %0d low cycles want 0", busy_bad); end
        n_cmp++; if (post_done !== 1'b0 || post_busy !== 1'b0) begin n_bad++; $display("FAIL wl_after_done got done=%b busy=%b want 0/0", post_done, post_busy); end
    endtask

    task automatic test_byte_load_sext();
        mem[8'hFF] = 8'h80;
        do_req(1'b1, 2'b00, 1'b1, 8'hFF, 32'h0, 0, -1);
        exp_rdata = 32'hFFFF_FF80;
        n_cmp++; if (done_cyc != 2) begin n_bad++; $display("FAIL bl_sext_done got %0d want 2", done_cyc); end
        n_cmp++; if (rdata !== exp_rdata) begin n_bad++; $display("FAIL bl_sext_rdata got %h want %h", rdata, exp_rdata); end
        do_req(1'b1, 2'b00, 1'b0, 8'hFF, 32'h0, 0, -1);
        exp_rdata = 32'h0000_0080;
        n_cmp++; if (done_cyc != 2) begin n_bad++; $display("FAIL bl_zext_done got %0d want 2", done_cyc); end
        n_cmp++; if (rdata !== exp_rdata) begin n_bad++; $display("FAIL bl_zext_rdata got %h want %h", rdata, exp_rdata); end
    endtask

    task automatic test_half_store();
        mem[8'hFE] = 8'h00; mem[8'hFF] = 8'h00;
        do_req(1'b0, 2'b01, 1'b0, 8'hFE, 32'hCAFE_BEEF, 3, -1);
        n_cmp++; if (done_cyc != 10) begin n_bad++; $display("FAIL hs_done_cycle got %0d want 10", done_cyc); end
        n_cmp++; if (mem[8'hFE] !== 8'hBE || mem[8'hFF] !== 8'hEF) begin n_bad++; $display("FAIL hs_bytes got %h %h want be ef", mem[8'hFE], mem[8'hFF]); end
        n_cmp++; if (n_addr != 2 || addr_log[0] !== 8'hFE || addr_log[1] !== 8'hFF) begin n_bad++; $display("FAIL hs_addr_seq got n=%0d %h %h want 2 fe ff", n_addr, addr_log[0], addr_log[1]); end
        n_cmp++; if (rdata !== exp_rdata) begin n_bad++; $display("FAIL hs_rdata_kept got %h want %h", rdata, exp_rdata); end
    endtask

    task automatic test_illegal_dt();
        do_req(1'b1, 2'b11, 1'b0, 8'h20, 32'h0, 0, -1);
        n_cmp++; if (err_cyc != 1) begin n_bad++; $display("FAIL ill_err_cycle got %0d want 1", err_cyc); end
        n_cmp++; if (mov_cnt != 0) begin n_bad++; $display("FAIL ill_no_access got %0d mov cycles want 0", mov_cnt); end
        n_cmp++; if (rdata !== exp_rdata || post_busy !== 1'b0) begin n_bad++; $display("FAIL ill_after got rdata=%h busy=%b want %h/0", rdata, post_busy, exp_rdata); end
    endtask

    task automatic test_misaligned();
        mem[8'h02] = 8'hA1; mem[8'h03] = 8'hB2; mem[8'h04] = 8'hC3; mem[8'h05] = 8'hD4;
        do_req(1'b1, 2'b10, 1'b0, 8'h02, 32'h0, 0, -1);
`ifdef MAU_ALIGN_CHECK_EN
        n_cmp++; if (err_cyc != 1 || mov_cnt != 0) begin n_bad++; $display("FAIL mis_err got cyc=%0d mov=%0d want 1/0", err_cyc, mov_cnt); end
        n_cmp++; if (rdata !== exp_rdata) begin n_bad++; $display("FAIL mis_rdata got %h want %h", rdata, exp_rdata); end
`else
        exp_rdata = 32'hA1B2_C3D4;
        n_cmp++; if (done_cyc != 8 || err_cyc != -1) begin n_bad++; $display("FAIL mis_done got done=%0d err=%0d want 8/-1", done_cyc, err_cyc); end
        n_cmp++; if (rdata !== exp_rdata) begin n_bad++; $display("FAIL mis_rdata got %h want %h", rdata, exp_rdata); end
        n_cmp++; if (addr_log[0] !== 8'h02 || addr_log[3] !== 8'h05) begin n_bad++; $display("FAIL mis_addr got %h..%h want 02..05", addr_log[0], addr_log[3]); end
`endif
    endtask

    task automatic test_timeout();
        do_req(1'b1, 2'b10, 1'b0, 8'h30, 32'h0, -1, -1);
        n_cmp++; if (err_cyc != 16) begin n_bad++; $display("FAIL to_err_cycle got %0d want 16", err_cyc); end
        n_cmp++; if (mov_cnt != 15 || err_mov !== 1'b0) begin n_bad++; $display("FAIL to_mov got cnt=%0d at_err=%b want 15/0", mov_cnt, err_mov); end
        n_cmp++; if (rdata !== exp_rdata || done_cyc != -1) begin n_bad++; $display("FAIL to_rdata got %h done=%0d want %h/-1", rdata, done_cyc, exp_rdata); end
    endtask

    task automatic test_clr_abort();
        int spur = 0;
        for (int a = 'h40; a <= 'h43; a++) mem[a] = 8'h00;
        do_req(1'b0, 2'b10, 1'b0, 8'h40, 32'h1122_3344, 0, 3);
        n_cmp++; if (mem_mov !== 1'b1 || mem_addr !== 8'h41 || mem_wdata !== 8'h22) begin
            n_bad++; $display("FAIL clr_pre got mov=%b addr=%h wdata=%h want 1/41/22", mem_mov, mem_addr, mem_wdata);
        end
        #1 clr = 1'b1;
        #1;
        n_cmp++; if ({busy, done, err, mem_mov, mem_rw} !== 5'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00 || rdata !== 32'h0) begin
            n_bad++; $display("FAIL clr_async got flags=%b addr=%h wdata=%h rdata=%h want 0", {busy, done, err, mem_mov, mem_rw}, mem_addr, mem_wdata, rdata);
        end
        exp_rdata = 32'h0;
        @(negedge clk);
        clr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) spur++;
        end
        n_cmp++; if (spur != 0) begin n_bad++; $display("FAIL clr_no_pulse got %0d active cycles want 0", spur); end
        do_req(1'b1, 2'b10, 1'b0, 8'h40, 32'h0, 0, -1);
        exp_rdata = 32'h1100_0000;
        n_cmp++; if (done_cyc != 8 || rdata !== exp_rdata) begin n_bad++; $display("FAIL clr_reload got done=%0d rdata=%h want 8/%h", done_cyc, rdata, exp_rdata); end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        test_reset();
        test_word_load();
        test_byte_load_sext();
        test_half_store();
        test_illegal_dt();
        test_misaligned();
        test_timeout();
        test_clr_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
